// File: rtl/lfsr8_pkg.sv
// Shared definitions for the 8-bit LFSR generator and its receive-side checker.
package lfsr8_pkg;

    localparam logic [7:0] LFSR8_LOCKUP = 8'h00;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:4], s[7] ^ s[3], s[7] ^ s[2], s[7] ^ s[1], s[0], s[7]};
    endfunction

endpackage

// File: rtl/lfsr8_checker.sv
// Self-synchronising checker for the 8-bit LFSR stream: hunts, verifies, then
// flywheels its own prediction to flag and count corrupted words.
module lfsr8_checker
    import lfsr8_pkg::*;
#(
    parameter int         LOCK_COUNT  = 4,
    parameter int         LOSS_COUNT  = 3,
    parameter int         ERR_W       = 16,
    parameter logic [7:0] ALIGN_VALUE = 8'd17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             align
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

    localparam logic [MATCH_W-1:0] LOCK_AT = MATCH_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]  LOSS_AT = MISS_W'(LOSS_COUNT);
    localparam logic [ERR_W-1:0]   ERR_MAX = {ERR_W{1'b1}};

    chk_state_t         state_q, state_d;
    logic [7:0]         pred_q, pred_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               align_q, align_d;

    logic               hit;
    logic [MATCH_W-1:0] match_inc;
    logic [MISS_W-1:0]  miss_inc;

    assign hit       = (in_data == pred_q);
    assign match_inc = match_cnt_q + MATCH_W'(1);
    assign miss_inc  = miss_cnt_q + MISS_W'(1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d     = state_q;
        pred_d      = pred_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        align_d     = 1'b0;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_data != LFSR8_LOCKUP) begin
                        pred_d      = lfsr8_next(in_data);
                        match_cnt_d = '0;
                        state_d     = VERIFY;
                    end
                end

                VERIFY: begin
                    if (hit) begin
                        pred_d      = lfsr8_next(in_data);
                        match_cnt_d = match_inc;
                        if (match_inc == LOCK_AT) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else if (in_data != LFSR8_LOCKUP) begin
                        pred_d      = lfsr8_next(in_data);
                        match_cnt_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end

                LOCKED: begin
                    // Flywheel: once locked the prediction never follows the input.
                    pred_d = lfsr8_next(pred_q);
                    if (hit) begin
                        miss_cnt_d = '0;
                        align_d    = (in_data == ALIGN_VALUE);
                    end else begin
                        err_pulse_d = 1'b1;
                        miss_cnt_d  = miss_inc;
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        if (miss_inc == LOSS_AT) begin
                            state_d = HUNT;
                        end
                    end
                end

                default: state_d = HUNT;
            endcase
        end

        if (clear_err) begin
            err_count_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HUNT;
            pred_q      <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_count_q <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            align_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_count_q <= err_count_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            align_q     <= align_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign align     = align_q;

endmodule

// File: tb/tb_lfsr8_checker.sv
// Scenario bench for lfsr8_checker: two instances (default and small-counter
// variant) checked against a word-level behavioural model.
module tb_lfsr8_checker;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_data0, in_data1;
    logic        in_valid0, in_valid1;
    logic        clear_err0, clear_err1;
    logic        locked0, locked1;
    logic        err_pulse0, err_pulse1;
    logic        align0, align1;
    logic [15:0] err_count0;
    logic [1:0]  err_count1;

    int checks   = 0;
    int failures = 0;

    lfsr8_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(16), .ALIGN_VALUE(8'd17)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data0), .in_valid(in_valid0),
        .clear_err(clear_err0), .locked(locked0), .err_pulse(err_pulse0),
        .err_count(err_count0), .align(align0)
    );

    lfsr8_checker #(.LOCK_COUNT(4), .LOSS_COUNT(8), .ERR_W(2), .ALIGN_VALUE(8'd17)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data1), .in_valid(in_valid1),
        .clear_err(clear_err1), .locked(locked1), .err_pulse(err_pulse1),
        .err_count(err_count1), .align(align1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 = hunting, 1 = verifying, 2 = locked.
    int p_lock [2] = '{4, 4};
    int p_loss [2] = '{3, 8};
    int p_max  [2] = '{65535, 3};
    int m_mode [2];
    int m_pred [2];
    int m_cnt  [2];
    int m_miss [2];
    int m_err  [2];
    bit m_pulse[2];
    bit m_align[2];

    // Galois form of the generator step: shift left, fold the MSB back in with 0x1D.
    function automatic int nx(input int s);
        int r;
        r = (s << 1) & 255;
        if ((s & 128) != 0) r = r ^ 'h1D;
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_pred[i] = 0; m_cnt[i] = 0; m_miss[i] = 0;
            m_err[i] = 0; m_pulse[i] = 0; m_align[i] = 0;
        end
    endfunction

    function automatic void model_step(input int i, input bit v, input int d, input bit clr);
        m_pulse[i] = 0;
        m_align[i] = 0;
        if (v) begin
            if (m_mode[i] == 0) begin
                if (d != 0) begin
                    m_pred[i] = nx(d); m_cnt[i] = 0; m_mode[i] = 1;
                end
            end else if (m_mode[i] == 1) begin
                if (d == m_pred[i]) begin
                    m_pred[i] = nx(d);
                    m_cnt[i]++;
                    if (m_cnt[i] == p_lock[i]) begin
                        m_mode[i] = 2; m_miss[i] = 0;
                    end
                end else if (d != 0) begin
                    m_pred[i] = nx(d); m_cnt[i] = 0;
                end else begin
                    m_mode[i] = 0;
                end
            end else begin
                if (d == m_pred[i]) begin
                    m_miss[i] = 0;
                    m_align[i] = (d == 17);
                end else begin
                    m_pulse[i] = 1;
                    if (m_err[i] < p_max[i]) m_err[i]++;
                    m_miss[i]++;
                    if (m_miss[i] == p_loss[i]) m_mode[i] = 0;
                end
                m_pred[i] = nx(m_pred[i]);
            end
        end
        if (clr) m_err[i] = 0;
    endfunction

    function automatic logic [18:0] obs(input int i);
        if (i == 0) return {locked0, err_pulse0, align0, err_count0};
        return {locked1, err_pulse1, align1, 14'd0, err_count1};
    endfunction

    function automatic logic [18:0] exp_obs(input int i);
        return {m_mode[i] == 2, m_pulse[i], m_align[i], 16'(m_err[i])};
    endfunction

    // Drives one clock cycle on instance i (the other idles), then samples 1 time unit after the edge.
    task automatic cycle(input int i, input bit v, input int d, input bit clr);
        in_valid0  = (i == 0) ? v : 1'b0;
        in_data0   = (i == 0) ? 8'(d) : 8'h00;
        clear_err0 = (i == 0) ? clr : 1'b0;
        in_valid1  = (i == 1) ? v : 1'b0;
        in_data1   = (i == 1) ? 8'(d) : 8'h00;
        clear_err1 = (i == 1) ? clr : 1'b0;
        @(posedge clk);
        model_step(0, in_valid0, int'(in_data0), clear_err0);
        model_step(1, in_valid1, int'(in_data1), clear_err1);
        #1;
    endtask

    task automatic do_reset();
        in_valid0 = 0; in_data0 = 0; clear_err0 = 0;
        in_valid1 = 0; in_data1 = 0; clear_err1 = 0;
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic send_lock_seq(input int i, input string tag);
        int seq [5] = '{'h0F, 'h1E, 'h3C, 'h78, 'hF0};
        for (int k = 0; k < 5; k++) begin
            cycle(i, 1'b1, seq[k], 1'b0);
            checks++;
            if (obs(i) !== exp_obs(i)) begin
                failures++;
                $display("FAIL %s word=%0d got=%h expected=%h", tag, k, obs(i), exp_obs(i));
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid0 = 0; in_data0 = 0; clear_err0 = 0;
        in_valid1 = 0; in_data1 = 0; clear_err1 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== 19'd0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got=%h expected=0", i, obs(i));
            end
        end
        reset_n = 1'b1;
        cycle(0, 1'b0, 0, 1'b0);
        checks++;
        if (obs(0) !== exp_obs(0) || locked0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got=%h expected=%h", obs(0), exp_obs(0));
        end
    endtask

    task automatic test_lock();
        do_reset();
        send_lock_seq(0, "lock_seq");
        checks++;
        if (locked0 !== 1'b1 || err_count0 !== 16'd0) begin
            failures++;
            $display("FAIL lock_after_f0 locked=%b err=%0d expected locked=1 err=0", locked0, err_count0);
        end
    endtask

    task automatic test_stall();
        int seq [8] = '{'h0F, 'h1E, 'h3C, 0, 0, 0, 'h78, 'hF0};
        bit vld [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(0, vld[k], vld[k] ? seq[k] : $urandom_range(0, 255), 1'b0);
            checks++;
            if (obs(0) !== exp_obs(0) || err_pulse0 !== 1'b0) begin
                failures++;
                $display("FAIL stall step=%0d got=%h expected=%h", k, obs(0), exp_obs(0));
            end
        end
        checks++;
        if (locked0 !== 1'b1) begin
            failures++;
            $display("FAIL stall_lock locked=%b expected=1", locked0);
        end
    endtask

    task automatic test_single_error();
        int s;
        do_reset();
        send_lock_seq(0, "single_err_lock");
        s = 'hFD;
        cycle(0, 1'b1, 'hFC, 1'b0);
        checks++;
        if (err_pulse0 !== 1'b1 || err_count0 !== 16'd1 || locked0 !== 1'b1) begin
            failures++;
            $display("FAIL single_err_pulse pulse=%b err=%0d locked=%b expected 1/1/1",
                     err_pulse0, err_count0, locked0);
        end
        for (int k = 0; k < 10; k++) begin
            s = nx(s);
            cycle(0, 1'b1, s, 1'b0);
            checks++;
            if (obs(0) !== exp_obs(0)) begin
                failures++;
                $display("FAIL single_err_follow k=%0d got=%h expected=%h", k, obs(0), exp_obs(0));
            end
        end
        checks++;
        if (err_count0 !== 16'd1 || locked0 !== 1'b1) begin
            failures++;
            $display("FAIL single_err_final err=%0d locked=%b expected err=1 locked=1", err_count0, locked0);
        end
    endtask

    task automatic test_back_to_back_loss();
        int p;
        do_reset();
        send_lock_seq(0, "loss_lock");
        p = 'hFD;
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 1'b1, p ^ $urandom_range(1, 255), 1'b0);
            p = nx(p);
            checks++;
            if (err_pulse0 !== 1'b1 || err_count0 !== 16'(k) || locked0 !== (k < 3)) begin
                failures++;
                $display("FAIL loss_miss%0d pulse=%b err=%0d locked=%b expected pulse=1 err=%0d locked=%b",
                         k, err_pulse0, err_count0, locked0, k, k < 3);
            end
        end
        send_lock_seq(0, "relock_seq");
        checks++;
        if (locked0 !== 1'b1 || err_count0 !== 16'd3) begin
            failures++;
            $display("FAIL relock locked=%b err=%0d expected locked=1 err=3", locked0, err_count0);
        end
    endtask

    task automatic test_lockup();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cycle(0, 1'b1, 0, 1'b0);
            checks++;
            if (locked0 !== 1'b0 || obs(0) !== exp_obs(0)) begin
                failures++;
                $display("FAIL lockup k=%0d got=%h expected locked=0", k, obs(0));
            end
        end
        // A nonzero word must still seed after the zero run; one word alone cannot lock.
        cycle(0, 1'b1, 'h0F, 1'b0);
        checks++;
        if (obs(0) !== exp_obs(0) || locked0 !== 1'b0) begin
            failures++;
            $display("FAIL lockup_seed got=%h expected=%h", obs(0), exp_obs(0));
        end
    endtask

    task automatic test_saturation();
        int p;
        do_reset();
        send_lock_seq(1, "sat_lock");
        p = 'hFD;
        for (int k = 1; k <= 5; k++) begin
            cycle(1, 1'b1, p ^ $urandom_range(1, 255), 1'b0);
            p = nx(p);
            checks++;
            if (err_count1 !== 2'((k < 3) ? k : 3) || locked1 !== 1'b1) begin
                failures++;
                $display("FAIL sat_miss%0d err=%0d locked=%b expected err=%0d locked=1",
                         k, err_count1, locked1, (k < 3) ? k : 3);
            end
        end
        cycle(1, 1'b1, p ^ 'h55, 1'b1);
        checks++;
        if (err_count1 !== 2'd0 || err_pulse1 !== 1'b1) begin
            failures++;
            $display("FAIL sat_clear err=%0d pulse=%b expected err=0 pulse=1", err_count1, err_pulse1);
        end
    endtask

    task automatic test_align();
        int seed = 1;
        int s;
        for (int c = 1; c < 256; c++) begin
            s = c;
            for (int k = 0; k < 5; k++) s = nx(s);
            if (s == 17) seed = c;
        end
        do_reset();
        s = seed;
        for (int k = 0; k < 7; k++) begin
            cycle(0, 1'b1, s, 1'b0);
            checks++;
            if (obs(0) !== exp_obs(0) || align0 !== (k == 5)) begin
                failures++;
                $display("FAIL align k=%0d word=%h align=%b expected=%b got=%h model=%h",
                         k, s, align0, k == 5, obs(0), exp_obs(0));
            end
            s = nx(s);
        end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        send_lock_seq(0, "midrst_lock");
        cycle(0, 1'b1, 'h00, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs(0) !== 19'd0) begin
            failures++;
            $display("FAIL mid_reset got=%h expected=0", obs(0));
        end
        @(negedge clk);
        reset_n = 1'b1;
        cycle(0, 1'b1, 'hF0, 1'b0);
        checks++;
        if (obs(0) !== exp_obs(0) || locked0 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_hunt got=%h expected=%h", obs(0), exp_obs(0));
        end
    endtask

    task automatic test_random(input int i, input int n);
        int g;
        int d;
        bit v;
        do_reset();
        g = $urandom_range(1, 255);
        for (int k = 0; k < n; k++) begin
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) g = $urandom_range(1, 255);
            d = g;
            if ($urandom_range(0, 9) == 0) d = g ^ $urandom_range(1, 255);
            if ($urandom_range(0, 49) == 0) d = 0;
            cycle(i, v, d, $urandom_range(0, 99) == 0);
            if (v) g = nx(g);
            checks++;
            if (obs(i) !== exp_obs(i)) begin
                failures++;
                $display("FAIL random inst=%0d k=%0d got=%h expected=%h", i, k, obs(i), exp_obs(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_stall();
        test_single_error();
        test_back_to_back_loss();
        test_lockup();
        test_saturation();
        test_align();
        test_reset_mid_lock();
        test_random(0, 2000);
        test_random(1, 800);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr8_checker.md
# lfsr8_checker

Receive-side companion to the 8-bit LFSR generator: it consumes the generator's 8-bit state stream, self-synchronises to it, and then free-runs its own prediction (flywheel) to flag and count corrupted words. It sits at the far end of a PRBS link or loopback path, alongside link bring-up and BER-measurement logic. It also reports lock status and a single-cycle alignment marker.

## Interface
- `LOCK_COUNT`, default 4: consecutive correct predictions required to declare lock (≥1).
- `LOSS_COUNT`, default 3: consecutive mismatches while locked that drop lock (≥1).
- `ERR_W`, default 16: width of the error counter.
- `ALIGN_VALUE`, default 8'd17: word value that raises `align` while locked.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_data` in 8: received LFSR state word.
- `in_valid` in 1: `in_data` is valid this cycle.
- `clear_err` in 1: synchronous clear of `err_count`.
- `locked` out 1: checker is in LOCKED.
- `err_pulse` out 1: one-cycle pulse per mismatched word while locked.
- `err_count` out ERR_W: saturating count of mismatches while locked.
- `align` out 1: one-cycle pulse, locked and a matching word equals `ALIGN_VALUE`.

## Operation
- Step function (identical to generator): next(s) = {s[6:4], s[7]^s[3], s[7]^s[2], s[7]^s[1], s[0], s[7]}. 8'h00 is the lockup state and is never a valid seed.
- States: HUNT, VERIFY, LOCKED. Internal: `pred[7:0]`, `match_cnt`, `miss_cnt`.
- Cycles with `in_valid`=0: no state, counter or `pred` change; all pulse outputs 0.
- HUNT: valid and `in_data`≠0 → `pred`←next(in_data), `match_cnt`←0, go VERIFY. Valid and `in_data`=0 → stay.
- VERIFY: valid and `in_data`=`pred` → `pred`←next(in_data), `match_cnt`+1; on reaching `LOCK_COUNT` → LOCKED, `miss_cnt`←0. Mismatch with `in_data`≠0 → reseed `pred`←next(in_data), `match_cnt`←0, stay VERIFY. Mismatch with `in_data`=0 → HUNT.
- LOCKED: every valid word → `pred`←next(pred) (flywheel, never reseeded from input).
  - Match → `miss_cnt`←0.
  - Mismatch → `err_pulse`, `err_count`+1 (saturates at all-ones), `miss_cnt`+1.
  - `miss_cnt` reaching `LOSS_COUNT` → HUNT. The word that causes loss still counts as an error.
- `err_count` only increments in LOCKED. It holds its value across loss and relock.
- `clear_err` has priority over a same-cycle increment: result is 0.
- `align`: LOCKED, valid, `in_data`=`pred`=`ALIGN_VALUE`.

## Timing
- Reset values: state HUNT, `pred` 0, both counters 0, `locked` 0, `err_pulse` 0, `err_count` 0, `align` 0.
- All outputs are registered. A word sampled at edge N affects outputs after edge N (visible in cycle N+1).
- Lock latency: 1 seed word + `LOCK_COUNT` matching words. `locked` rises the cycle after the last matching word.
- `err_pulse` and `align` are high for exactly one cycle per qualifying valid word. Back-to-back valid words give back-to-back pulses.
- `locked` falls the cycle after the `LOSS_COUNT`-th consecutive mismatch, the same cycle as that word's `err_pulse`.
- Asserting reset mid-lock returns to HUNT immediately and clears all outputs, including `err_count`.

## Structure
- Shared package `lfsr8_pkg`:
  - `lfsr8_next()` step function, used by both generator and checker.
  - State enum `chk_state_t` (HUNT/VERIFY/LOCKED).
  - Constant `LFSR8_LOCKUP` = 8'h00.
- No sub-module. This is a single FSM with datapath, roughly 150–200 lines.

## Test plan
- Lock: after reset, feed valid 0F,1E,3C,78,F0 back-to-back → `locked`=1 in the cycle after F0; `err_count`=0.
- Stall tolerance: same sequence with `in_valid` low for 3 cycles between 3C and 78 → still locks after F0; no `err_pulse`.
- Single error: locked, expected FD sent as FC, then correct sequence continues → one `err_pulse`, `err_count`=1, `locked` stays 1.
- Loss: locked, 3 consecutive wrong words → `err_count`=3; `locked` drops with the 3rd pulse; state HUNT; valid 0F then 1E,3C,78,F0 relocks.
- Lockup seed: stream of 00 from reset → never leaves HUNT; `locked`=0.
- Clear/saturation: with ERR_W=2, drive 5 mismatches with LOSS_COUNT=8 → `err_count` sticks at 3. Assert `clear_err` on a mismatch cycle → 0.
